// File: rtl/regfile_operand_fetch_pkg.sv
// Shared pipeline definitions for the register file / operand-fetch stage.
//   DATA_W, ADDR_W, NUM_REGS : datapath and register-file geometry
//   REG_ZERO                 : hard-wired zero register address
//   id_ex_t                  : operand bundle crossing the ID/EX boundary
//   wb_clr()                 : true when writeback retires register a this cycle
package regfile_operand_fetch_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              writes;
  } id_ex_t;

  // Writeback to a non-zero register a in this cycle
  function automatic logic wb_clr(input logic              en,
                                  input logic [ADDR_W-1:0] waddr,
                                  input logic [ADDR_W-1:0] a);
    return en && (waddr == a) && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_operand_fetch_2r1w.sv
// Two-read / one-write register file with write-to-read bypass.
//   clk, reset              : clock, synchronous active-high reset (clears storage)
//   wr_en, wr_addr, wr_data : write port; writes to register 0 are dropped
//   ra_addr / ra_data_c     : combinational read port A
//   rb_addr / rb_data_c     : combinational read port B
// Register 0 always reads zero; a read of the register being written this
// cycle returns the incoming write data.
module regfile_2r1w
  import regfile_operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data_c,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data_c
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  // Write port next-state; entry 0 is held at zero
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en && (wr_addr != REG_ZERO)) begin
      mem_d[wr_addr] = wr_data;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read ports: zero register first, then bypass, then storage
  always_comb begin
    ra_data_c = mem_q[ra_addr];
    if (ra_addr == REG_ZERO) begin
      ra_data_c = '0;
    end else if (wb_clr(wr_en, wr_addr, ra_addr)) begin
      ra_data_c = wr_data;
    end
  end

  always_comb begin
    rb_data_c = mem_q[rb_addr];
    if (rb_addr == REG_ZERO) begin
      rb_data_c = '0;
    end else if (wb_clr(wr_en, wr_addr, rb_addr)) begin
      rb_data_c = wr_data;
    end
  end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Register file plus operand-fetch stage feeding the ID/EX boundary.
//   clk, reset                          : clock, synchronous active-high reset
//   id_valid, rs/rt/rd_addr, id_writes  : instruction presented by decode
//   wb_en, wb_addr, wb_data             : writeback result
//   stall                               : combinational; decode must hold
//   ex_valid, rs/rt_data_ex, rd_addr_ex,
//   ex_writes                           : registered ID/EX operand bundle
// A one-bit-per-register pending scoreboard tracks in-flight writes and
// stalls issue on RAW/WAW hazards that this cycle's writeback does not clear.
module regfile_operand_fetch
  import regfile_operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              id_writes,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] rs_data_ex,
  output logic [DATA_W-1:0] rt_data_ex,
  output logic [ADDR_W-1:0] rd_addr_ex,
  output logic              ex_writes
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  id_ex_t              ex_q, ex_d;
  logic [DATA_W-1:0]   rs_data_c, rt_data_c;
  logic                raw_c, waw_c, accept_c;

  regfile_2r1w u_rf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .ra_addr   (rs_addr),
    .ra_data_c (rs_data_c),
    .rb_addr   (rt_addr),
    .rb_data_c (rt_data_c)
  );

  // Hazards: a pending bit retired by this cycle's writeback does not block
  always_comb begin
    raw_c = (pending_q[rs_addr] && !wb_clr(wb_en, wb_addr, rs_addr)) ||
            (pending_q[rt_addr] && !wb_clr(wb_en, wb_addr, rt_addr));
    waw_c = id_writes && pending_q[rd_addr] && !wb_clr(wb_en, wb_addr, rd_addr);
    stall    = id_valid && (raw_c || waw_c);
    accept_c = id_valid && !stall;
  end

  // Scoreboard: a new issue setting a bit wins over a retiring write
  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (accept_c && id_writes && (rd_addr == ADDR_W'(i))) begin
        pending_d[i] = 1'b1;
      end else if (wb_clr(wb_en, wb_addr, ADDR_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
    pending_d[0] = 1'b0;
  end

  // ID/EX register: bubble on no-accept, data/address hold their last values
  always_comb begin
    ex_d        = ex_q;
    ex_d.valid  = 1'b0;
    ex_d.writes = 1'b0;
    if (accept_c) begin
      ex_d.valid   = 1'b1;
      ex_d.rs_data = rs_data_c;
      ex_d.rt_data = rt_data_c;
      ex_d.rd_addr = rd_addr;
      ex_d.writes  = id_writes;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      ex_q      <= '0;
    end else begin
      pending_q <= pending_d;
      ex_q      <= ex_d;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign rs_data_ex = ex_q.rs_data;
  assign rt_data_ex = ex_q.rt_data;
  assign rd_addr_ex = ex_q.rd_addr;
  assign ex_writes  = ex_q.writes;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Directed self-checking bench for regfile_operand_fetch.
module tb_regfile_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [3:0]  rs_addr, rt_addr, rd_addr;
  logic        id_writes;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall;
  logic        ex_valid;
  logic [15:0] rs_data_ex, rt_data_ex;
  logic [3:0]  rd_addr_ex;
  logic        ex_writes;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_operand_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .id_writes  (id_writes),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .rs_data_ex (rs_data_ex),
    .rt_data_ex (rt_data_ex),
    .rd_addr_ex (rd_addr_ex),
    .ex_writes  (ex_writes)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                          input logic [3:0] rd, input logic w);
    id_valid = v; rs_addr = rs; rt_addr = rt; rd_addr = rd; id_writes = w;
  endtask

  task automatic drive_wb(input logic en, input logic [3:0] a, input logic [15:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_id(1'b1, 4'd1, 4'd2, 4'd3, 1'b1);
    drive_wb(1'b1, 4'd1, 16'hDEAD);
    step();
    step();
    reset = 1'b0;
    drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    drive_wb(1'b0, 4'd0, 16'h0);
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    n_cmp++; if (rs_data_ex !== 16'h0) begin n_err++; $display("FAIL reset_rs_data got=%h exp=0000", rs_data_ex); end
    n_cmp++; if (rt_data_ex !== 16'h0) begin n_err++; $display("FAIL reset_rt_data got=%h exp=0000", rt_data_ex); end
    n_cmp++; if (rd_addr_ex !== 4'h0) begin n_err++; $display("FAIL reset_rd_addr got=%h exp=0", rd_addr_ex); end
    n_cmp++; if (ex_writes !== 1'b0) begin n_err++; $display("FAIL reset_ex_writes got=%b exp=0", ex_writes); end
  endtask

  task automatic test_basic_issue();
    drive_id(1'b1, 4'd3, 4'd4, 4'd0, 1'b0);
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL basic_stall got=%b exp=0", stall); end
    step();
    drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL basic_ex_valid got=%b exp=1", ex_valid); end
    n_cmp++; if (rs_data_ex !== 16'h0) begin n_err++; $display("FAIL basic_rs got=%h exp=0000", rs_data_ex); end
    n_cmp++; if (rt_data_ex !== 16'h0) begin n_err++; $display("FAIL basic_rt got=%h exp=0000", rt_data_ex); end
  endtask

  task automatic test_bypass();
    // Same-cycle write and read of r5; r5 was never pending
    drive_wb(1'b1, 4'd5, 16'h1234);
    drive_id(1'b1, 4'd5, 4'd0, 4'd0, 1'b0);
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL bypass_stall got=%b exp=0", stall); end
    step();
    drive_wb(1'b0, 4'd0, 16'h0);
    n_cmp++; if (rs_data_ex !== 16'h1234) begin n_err++; $display("FAIL bypass_rs got=%h exp=1234", rs_data_ex); end
    n_cmp++; if (rt_data_ex !== 16'h0) begin n_err++; $display("FAIL bypass_rt0 got=%h exp=0000", rt_data_ex); end
    // Later read from storage on the second port
    drive_id(1'b1, 4'd3, 4'd5, 4'd0, 1'b0);
    step();
    drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_cmp++; if (rt_data_ex !== 16'h1234) begin n_err++; $display("FAIL stored_rt got=%h exp=1234", rt_data_ex); end
    // Idle: bubble, data holds
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL idle_ex_valid got=%b exp=0", ex_valid); end
    n_cmp++; if (rt_data_ex !== 16'h1234) begin n_err++; $display("FAIL idle_hold_rt got=%h exp=1234", rt_data_ex); end
  endtask

  task automatic test_raw();
    drive_id(1'b1, 4'd0, 4'd0, 4'd7, 1'b1);
    step();
    n_cmp++; if (ex_writes !== 1'b1) begin n_err++; $display("FAIL raw_prod_writes got=%b exp=1", ex_writes); end
    n_cmp++; if (rd_addr_ex !== 4'd7) begin n_err++; $display("FAIL raw_prod_rd got=%h exp=7", rd_addr_ex); end
    drive_id(1'b1, 4'd7, 4'd0, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL raw_stall[%0d] got=%b exp=1", i, stall); end
      step();
      n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL raw_bubble[%0d] got=%b exp=0", i, ex_valid); end
      n_cmp++; if (ex_writes !== 1'b0) begin n_err++; $display("FAIL raw_bubble_wr[%0d] got=%b exp=0", i, ex_writes); end
    end
    drive_wb(1'b1, 4'd7, 16'h00AA);
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL raw_release got=%b exp=0", stall); end
    step();
    drive_wb(1'b0, 4'd0, 16'h0);
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL raw_issue_valid got=%b exp=1", ex_valid); end
    n_cmp++; if (rs_data_ex !== 16'h00AA) begin n_err++; $display("FAIL raw_issue_rs got=%h exp=00aa", rs_data_ex); end
    // Pending bit for r7 is now clear: the same read issues immediately
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL raw_cleared got=%b exp=0", stall); end
    step();
    drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_cmp++; if (rs_data_ex !== 16'h00AA) begin n_err++; $display("FAIL raw_reread got=%h exp=00aa", rs_data_ex); end
  endtask

  task automatic test_waw();
    drive_id(1'b1, 4'd0, 4'd0, 4'd9, 1'b1);
    step();
    #2;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL waw_stall got=%b exp=1", stall); end
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL waw_bubble got=%b exp=0", ex_valid); end
    // Retire first write; second issues in the same cycle and re-sets pending
    drive_wb(1'b1, 4'd9, 16'h0909);
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL waw_release got=%b exp=0", stall); end
    step();
    drive_wb(1'b0, 4'd0, 16'h0);
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL waw_issue got=%b exp=1", ex_valid); end
    n_cmp++; if (ex_writes !== 1'b1) begin n_err++; $display("FAIL waw_issue_wr got=%b exp=1", ex_writes); end
    n_cmp++; if (rd_addr_ex !== 4'd9) begin n_err++; $display("FAIL waw_issue_rd got=%h exp=9", rd_addr_ex); end
    drive_id(1'b1, 4'd9, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #2;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL waw_pending_kept[%0d] got=%b exp=1", i, stall); end
      step();
    end
    drive_wb(1'b1, 4'd9, 16'h9999);
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL waw_second_wb got=%b exp=0", stall); end
    step();
    drive_wb(1'b0, 4'd0, 16'h0);
    drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_cmp++; if (rs_data_ex !== 16'h9999) begin n_err++; $display("FAIL waw_read got=%h exp=9999", rs_data_ex); end
  endtask

  task automatic test_zero_reg();
    drive_wb(1'b1, 4'd0, 16'hFFFF);
    drive_id(1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall1 got=%b exp=0", stall); end
    step();
    drive_wb(1'b0, 4'd0, 16'h0);
    n_cmp++; if (rs_data_ex !== 16'h0) begin n_err++; $display("FAIL zero_bypass got=%h exp=0000", rs_data_ex); end
    n_cmp++; if (ex_writes !== 1'b1) begin n_err++; $display("FAIL zero_writes got=%b exp=1", ex_writes); end
    drive_id(1'b1, 4'd0, 4'd0, 4'd1, 1'b0);
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall2 got=%b exp=0", stall); end
    step();
    drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL zero_valid got=%b exp=1", ex_valid); end
    n_cmp++; if (rs_data_ex !== 16'h0) begin n_err++; $display("FAIL zero_read got=%h exp=0000", rs_data_ex); end
  endtask

  task automatic test_mid_reset();
    // Plain write to non-pending r7, then make r7 pending with ex_valid=1
    drive_wb(1'b1, 4'd7, 16'h7777);
    step();
    drive_wb(1'b0, 4'd0, 16'h0);
    drive_id(1'b1, 4'd7, 4'd0, 4'd7, 1'b1);
    step();
    n_cmp++; if (rs_data_ex !== 16'h7777) begin n_err++; $display("FAIL mid_pre_rs got=%h exp=7777", rs_data_ex); end
    // Reset overrides a simultaneous write and issue
    reset = 1'b1;
    drive_wb(1'b1, 4'd7, 16'hBEEF);
    drive_id(1'b1, 4'd3, 4'd5, 4'd6, 1'b1);
    step();
    reset = 1'b0;
    drive_wb(1'b0, 4'd0, 16'h0);
    drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got=%b exp=0", ex_valid); end
    n_cmp++; if (rs_data_ex !== 16'h0) begin n_err++; $display("FAIL mid_rs got=%h exp=0000", rs_data_ex); end
    n_cmp++; if (rd_addr_ex !== 4'h0) begin n_err++; $display("FAIL mid_rd got=%h exp=0", rd_addr_ex); end
    n_cmp++; if (ex_writes !== 1'b0) begin n_err++; $display("FAIL mid_writes got=%b exp=0", ex_writes); end
    drive_id(1'b1, 4'd7, 4'd5, 4'd0, 1'b0);
    #2;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_stall got=%b exp=0", stall); end
    step();
    drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_cmp++; if (ex_valid !== 1'b1) begin n_err++; $display("FAIL mid_issue got=%b exp=1", ex_valid); end
    n_cmp++; if (rs_data_ex !== 16'h0) begin n_err++; $display("FAIL mid_r7 got=%h exp=0000", rs_data_ex); end
    n_cmp++; if (rt_data_ex !== 16'h0) begin n_err++; $display("FAIL mid_r5 got=%h exp=0000", rt_data_ex); end
  endtask

  initial begin
    reset = 1'b1;
    drive_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    drive_wb(1'b0, 4'd0, 16'h0);
    test_reset();
    test_basic_issue();
    test_bypass();
    test_raw();
    test_waw();
    test_zero_reg();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
